// File: rtl/median3_row_stage.sv
// Purpose: streaming 1x3 horizontal median between two FIFOs, with edge replication at both line ends.
// Latency: pixel k popped at edge t puts output k-1 in the output slot at t+1. The line's last output comes from TAIL one cycle after its last pop.
// Backpressure: a one-slot output buffer; while out_full holds the slot, in_enr drops and nothing is lost.
module median3_row_stage #(
  parameter int size  = 8,
  parameter int width = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_empty,
  input  logic [size-1:0] in_data,
  output logic            in_enr,
  input  logic            out_full,
  output logic            out_enw,
  output logic [size-1:0] out_data,
  output logic            out_last
);

  localparam int CW = $clog2(width);
  localparam logic [CW-1:0] COL_LAST = CW'(width - 1);

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    RUN   = 2'd1,
    TAIL  = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [size-1:0] p0, p1, p0_nx, p1_nx;
  logic [CW-1:0]   col, col_nx;
  logic            obuf_v, obuf_v_nx;
  logic [size-1:0] out_data_nx;
  logic            out_last_nx;
  logic            slot_free;
  logic            load;
  logic [size-1:0] load_data;
  logic            load_last;

  // med(a,b,c) = max(min(a,b), min(max(a,b),c)), unsigned, no width growth
  function automatic logic [size-1:0] med3(input logic [size-1:0] a,
                                           input logic [size-1:0] b,
                                           input logic [size-1:0] c);
    logic [size-1:0] lo, hi, hc;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    hc = (hi < c) ? hi : c;
    return (lo < hc) ? hc : lo;
  endfunction

  // Handshake: the slot accepts a new value when it is empty or being drained this cycle
  always_comb begin
    out_enw   = obuf_v & ~out_full;
    slot_free = ~obuf_v | ~out_full;
    in_enr    = ~in_empty & slot_free & (state != TAIL);
  end

  // Next-state, window shift and slot load decisions
  always_comb begin
    state_nx    = state;
    p0_nx       = p0;
    p1_nx       = p1;
    col_nx      = col;
    load        = 1'b0;
    load_data   = out_data;
    load_last   = 1'b0;
    obuf_v_nx   = obuf_v;
    out_data_nx = out_data;
    out_last_nx = out_last;

    case (state)
      PRIME: begin
        // x0 fills both window taps: left edge replication, no output yet
        if (in_enr) begin
          p0_nx    = in_data;
          p1_nx    = in_data;
          col_nx   = CW'(1);
          state_nx = RUN;
        end
      end
      RUN: begin
        if (in_enr) begin
          load      = 1'b1;
          load_data = med3(p0, p1, in_data);
          load_last = 1'b0;
          p0_nx     = p1;
          p1_nx     = in_data;
          if (col == COL_LAST) begin
            col_nx   = '0;
            state_nx = TAIL;
          end else begin
            col_nx = col + CW'(1);
          end
        end
      end
      TAIL: begin
        // right edge replication: med(x[W-2], x[W-1], x[W-1]) is simply x[W-1]
        if (slot_free) begin
          load      = 1'b1;
          load_data = p1;
          load_last = 1'b1;
          state_nx  = PRIME;
        end
      end
      default: state_nx = PRIME;
    endcase

    if (load) begin
      obuf_v_nx   = 1'b1;
      out_data_nx = load_data;
      out_last_nx = load_last;
    end else if (out_enw) begin
      obuf_v_nx = 1'b0;
    end
  end

  // State, window and output slot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PRIME;
      p0       <= '0;
      p1       <= '0;
      col      <= '0;
      obuf_v   <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      state    <= state_nx;
      p0       <= p0_nx;
      p1       <= p1_nx;
      col      <= col_nx;
      obuf_v   <= obuf_v_nx;
      out_data <= out_data_nx;
      out_last <= out_last_nx;
    end
  end

endmodule
